// File: rtl/led_pkg.sv
// Shared state encoding and default timing for the LED status-code blinker.
package led_pkg;

  typedef enum logic [1:0] {StHb, StOn, StOff, StGap} led_state_e;

  localparam int unsigned DefTickDiv  = 2500000;
  localparam int unsigned DefOnTicks  = 2;
  localparam int unsigned DefOffTicks = 3;
  localparam int unsigned DefGapTicks = 15;
  localparam int unsigned DefHbTicks  = 6;

endpackage

// File: rtl/led_tick.sv
// Free-running prescaler: one-clock tick every P_TICK_DIV clocks.
module led_tick
  import led_pkg::*;
#(
  parameter int unsigned P_TICK_DIV = DefTickDiv
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CntW = $clog2(P_TICK_DIV);

  logic [CntW-1:0] cnt_q;

  assign tick = (cnt_q == CntW'(P_TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/led_code.sv
// Status LED: heartbeat for code 0, otherwise repeating blink-count sequences.
module led_code
  import led_pkg::*;
#(
  parameter int unsigned P_TICK_DIV  = DefTickDiv,
  parameter int unsigned P_ON_TICKS  = DefOnTicks,
  parameter int unsigned P_OFF_TICKS = DefOffTicks,
  parameter int unsigned P_GAP_TICKS = DefGapTicks,
  parameter int unsigned P_HB_TICKS  = DefHbTicks
) (
  input  logic       I_clk,
  input  logic       I_reset,
  input  logic [3:0] I_code,
  input  logic       I_code_vld,
  output logic       O_led,
  output logic [3:0] O_cur_code,
  output logic       O_pend
);

  localparam int unsigned MaxA     = (P_ON_TICKS > P_OFF_TICKS) ? P_ON_TICKS : P_OFF_TICKS;
  localparam int unsigned MaxB     = (P_GAP_TICKS > P_HB_TICKS) ? P_GAP_TICKS : P_HB_TICKS;
  localparam int unsigned MaxTicks = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned PhW      = $clog2(MaxTicks + 1);

  led_state_e       state_q, state_d;
  logic [PhW-1:0]   phase_q, phase_d;
  logic [3:0]       blink_q, blink_d;
  logic [3:0]       cur_q, cur_d;
  logic [3:0]       pend_code_q, pend_code_d;
  logic             pend_q, pend_d;
  logic             led_q, led_d;
  logic             tick;
  logic             commit;
  logic [3:0]       blink_inc;
  logic [3:0]       next_code;

  led_tick #(
    .P_TICK_DIV(P_TICK_DIV)
  ) u_tick (
    .clk  (I_clk),
    .reset(I_reset),
    .tick (tick)
  );

  assign blink_inc = blink_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    blink_d     = blink_q;
    cur_d       = cur_q;
    pend_code_d = pend_code_q;
    pend_d      = pend_q;
    led_d       = led_q;
    commit      = 1'b0;
    next_code   = cur_q;

    if (tick) begin
      unique case (state_q)
        StHb: begin
          if (pend_q) begin
            commit = 1'b1;
          end else if (phase_q == PhW'(P_HB_TICKS - 1)) begin
            phase_d = '0;
            led_d   = ~led_q;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        StOn: begin
          if (phase_q == PhW'(P_ON_TICKS - 1)) begin
            phase_d = '0;
            state_d = StOff;
            led_d   = 1'b0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        StOff: begin
          if (phase_q == PhW'(P_OFF_TICKS - 1)) begin
            phase_d = '0;
            blink_d = blink_inc;
            if (blink_inc == cur_q) begin
              state_d = StGap;
            end else begin
              state_d = StOn;
              led_d   = 1'b1;
            end
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        StGap: begin
          if (phase_q == PhW'(P_GAP_TICKS - 1)) begin
            commit = 1'b1;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        default: begin
          state_d = StHb;
          led_d   = 1'b0;
        end
      endcase
    end

    // Gap end without a pending code simply restarts the current code.
    if (commit) begin
      if (pend_q) begin
        next_code = pend_code_q;
        cur_d     = pend_code_q;
        pend_d    = 1'b0;
      end
      phase_d = '0;
      blink_d = '0;
      if (next_code != 4'd0) begin
        state_d = StOn;
        led_d   = 1'b1;
      end else begin
        state_d = StHb;
        led_d   = 1'b0;
      end
    end

    // A strobe on a commit edge waits for the next commit point.
    if (I_code_vld) begin
      pend_d      = 1'b1;
      pend_code_d = I_code;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q     <= StHb;
      phase_q     <= '0;
      blink_q     <= '0;
      cur_q       <= '0;
      pend_code_q <= '0;
      pend_q      <= 1'b0;
      led_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      blink_q     <= blink_d;
      cur_q       <= cur_d;
      pend_code_q <= pend_code_d;
      pend_q      <= pend_d;
      led_q       <= led_d;
    end
  end

  assign O_led      = led_q;
  assign O_cur_code = cur_q;
  assign O_pend     = pend_q;

endmodule

// File: tb/tb_led_code.sv
// Directed bench for led_code with short tick periods (4 clocks per tick).
module tb_led_code;
  import led_pkg::*;

  logic       I_clk;
  logic       I_reset;
  logic [3:0] I_code;
  logic       I_code_vld;
  logic       O_led;
  logic [3:0] O_cur_code;
  logic       O_pend;

  int total;
  int bad;

  led_code #(
    .P_TICK_DIV (4),
    .P_ON_TICKS (2),
    .P_OFF_TICKS(3),
    .P_GAP_TICKS(5),
    .P_HB_TICKS (3)
  ) dut (
    .I_clk     (I_clk),
    .I_reset   (I_reset),
    .I_code    (I_code),
    .I_code_vld(I_code_vld),
    .O_led     (O_led),
    .O_cur_code(O_cur_code),
    .O_pend    (O_pend)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  // Clocks for which O_led stays at lvl, bounded by lim.
  task automatic span(input logic lvl, input int lim, output int n);
    n = 0;
    while (O_led === lvl && n < lim) begin
      @(negedge I_clk);
      n++;
    end
  endtask

  task automatic strobe(input logic [3:0] code);
    I_code     = code;
    I_code_vld = 1'b1;
    @(negedge I_clk);
    I_code_vld = 1'b0;
  endtask

  task automatic test_reset;
    I_reset = 1'b1;
    repeat (3) @(negedge I_clk);
    total++;
    if (O_led !== 1'b0 || O_cur_code !== 4'd0 || O_pend !== 1'b0 || dut.state_q !== StHb) begin
      bad++;
      $display("FAIL reset led=%b cur=%0d pend=%b state=%0d want 0/0/0/HB",
               O_led, O_cur_code, O_pend, dut.state_q);
    end
    I_reset = 1'b0;
  endtask

  task automatic test_heartbeat;
    int n;
    span(1'b0, 100, n);
    total++;
    if (n !== 12) begin bad++; $display("FAIL hb_first got=%0d want=12", n); end
    span(1'b1, 100, n);
    total++;
    if (n !== 12) begin bad++; $display("FAIL hb_high got=%0d want=12", n); end
    span(1'b0, 100, n);
    total++;
    if (n !== 12) begin bad++; $display("FAIL hb_low got=%0d want=12", n); end
    total++;
    if (O_cur_code !== 4'd0 || O_pend !== 1'b0) begin
      bad++;
      $display("FAIL hb_status cur=%0d pend=%b want 0/0", O_cur_code, O_pend);
    end
  endtask

  task automatic test_blink3;
    int n;
    int exp_h[7] = '{8, 8, 8, 8, 8, 8, 8};
    int exp_l[6] = '{12, 12, 32, 0, 0, 0};
    strobe(4'd3);
    total++;
    if (O_pend !== 1'b1) begin bad++; $display("FAIL b3_pend got=%b want=1", O_pend); end
    n = 0;
    while (O_pend === 1'b1 && n < 10) begin
      @(negedge I_clk);
      n++;
    end
    total++;
    if (n > 4) begin bad++; $display("FAIL b3_pend_clear clocks=%0d want<=4", n); end
    total++;
    if (O_cur_code !== 4'd3) begin bad++; $display("FAIL b3_cur got=%0d want=3", O_cur_code); end
    for (int i = 0; i < 3; i++) begin
      span(1'b1, 100, n);
      total++;
      if (n !== exp_h[i]) begin bad++; $display("FAIL b3_high%0d got=%0d want=%0d", i, n, exp_h[i]); end
      span(1'b0, 100, n);
      total++;
      if (n !== exp_l[i]) begin bad++; $display("FAIL b3_low%0d got=%0d want=%0d", i, n, exp_l[i]); end
    end
    span(1'b1, 100, n);
    total++;
    if (n !== 8) begin bad++; $display("FAIL b3_repeat got=%0d want=8", n); end
  endtask

  task automatic test_mid_change;
    int n;
    span(1'b0, 100, n);
    total++;
    if (n !== 12) begin bad++; $display("FAIL mc_low0 got=%0d want=12", n); end
    strobe(4'd1);
    total++;
    if (O_pend !== 1'b1) begin bad++; $display("FAIL mc_pend got=%b want=1", O_pend); end
    span(1'b1, 100, n);
    total++;
    if (n !== 7) begin bad++; $display("FAIL mc_high2 got=%0d want=7", n); end
    span(1'b0, 100, n);
    total++;
    if (n !== 12) begin bad++; $display("FAIL mc_low2 got=%0d want=12", n); end
    total++;
    if (O_cur_code !== 4'd3 || O_pend !== 1'b1) begin
      bad++;
      $display("FAIL mc_third cur=%0d pend=%b want 3/1", O_cur_code, O_pend);
    end
    span(1'b1, 100, n);
    total++;
    if (n !== 8) begin bad++; $display("FAIL mc_high3 got=%0d want=8", n); end
    span(1'b0, 100, n);
    total++;
    if (n !== 32) begin bad++; $display("FAIL mc_gap got=%0d want=32", n); end
    total++;
    if (O_cur_code !== 4'd1 || O_pend !== 1'b0) begin
      bad++;
      $display("FAIL mc_commit cur=%0d pend=%b want 1/0", O_cur_code, O_pend);
    end
    for (int i = 0; i < 2; i++) begin
      span(1'b1, 100, n);
      total++;
      if (n !== 8) begin bad++; $display("FAIL mc_one_high%0d got=%0d want=8", i, n); end
      if (i == 0) begin
        span(1'b0, 100, n);
        total++;
        if (n !== 32) begin bad++; $display("FAIL mc_one_low got=%0d want=32", n); end
      end
    end
  endtask

  task automatic test_last_wins;
    int n;
    strobe(4'd5);
    @(negedge I_clk);
    strobe(4'd2);
    span(1'b0, 100, n);
    total++;
    if (n !== 29) begin bad++; $display("FAIL lw_gap got=%0d want=29", n); end
    total++;
    if (O_cur_code !== 4'd2 || O_pend !== 1'b0) begin
      bad++;
      $display("FAIL lw_commit cur=%0d pend=%b want 2/0", O_cur_code, O_pend);
    end
    span(1'b1, 100, n);
    total++;
    if (n !== 8) begin bad++; $display("FAIL lw_high0 got=%0d want=8", n); end
    span(1'b0, 100, n);
    total++;
    if (n !== 12) begin bad++; $display("FAIL lw_low0 got=%0d want=12", n); end
    span(1'b1, 100, n);
    total++;
    if (n !== 8) begin bad++; $display("FAIL lw_high1 got=%0d want=8", n); end
    span(1'b0, 100, n);
    total++;
    if (n !== 32 || O_cur_code !== 4'd2) begin
      bad++;
      $display("FAIL lw_gap2 got=%0d cur=%0d want 32/2", n, O_cur_code);
    end
  endtask

  task automatic test_limit;
    int n;
    int eh;
    int el;
    strobe(4'd15);
    span(1'b1, 100, n);
    total++;
    if (n !== 7) begin bad++; $display("FAIL lim_pre_high0 got=%0d want=7", n); end
    span(1'b0, 100, n);
    total++;
    if (n !== 12) begin bad++; $display("FAIL lim_pre_low0 got=%0d want=12", n); end
    span(1'b1, 100, n);
    total++;
    if (n !== 8) begin bad++; $display("FAIL lim_pre_high1 got=%0d want=8", n); end
    span(1'b0, 100, n);
    total++;
    if (n !== 32) begin bad++; $display("FAIL lim_pre_gap got=%0d want=32", n); end
    total++;
    if (O_cur_code !== 4'd15) begin bad++; $display("FAIL lim_cur got=%0d want=15", O_cur_code); end
    for (int i = 0; i < 15; i++) begin
      eh = 8;
      if (i == 4) begin
        strobe(4'd0);
        eh = 7;
      end
      el = (i == 14) ? 44 : 12;
      span(1'b1, 100, n);
      total++;
      if (n !== eh) begin bad++; $display("FAIL lim_high%0d got=%0d want=%0d", i, n, eh); end
      span(1'b0, 100, n);
      total++;
      if (n !== el) begin bad++; $display("FAIL lim_low%0d got=%0d want=%0d", i, n, el); end
    end
    total++;
    if (O_cur_code !== 4'd0 || O_pend !== 1'b0) begin
      bad++;
      $display("FAIL lim_hb_status cur=%0d pend=%b want 0/0", O_cur_code, O_pend);
    end
    span(1'b1, 100, n);
    total++;
    if (n !== 12) begin bad++; $display("FAIL lim_hb_high got=%0d want=12", n); end
  endtask

  task automatic test_reset_mid_on;
    int n;
    strobe(4'd3);
    n = 0;
    while (O_pend === 1'b1 && n < 10) begin
      @(negedge I_clk);
      n++;
    end
    repeat (2) @(negedge I_clk);
    total++;
    if (O_led !== 1'b1 || dut.state_q !== StOn) begin
      bad++;
      $display("FAIL rst_pre led=%b state=%0d want 1/ON", O_led, dut.state_q);
    end
    I_reset = 1'b1;
    @(negedge I_clk);
    total++;
    if (O_led !== 1'b0 || dut.state_q !== StHb || O_cur_code !== 4'd0 || O_pend !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_on led=%b state=%0d cur=%0d pend=%b want 0/HB/0/0",
               O_led, dut.state_q, O_cur_code, O_pend);
    end
    I_reset = 1'b0;
    span(1'b0, 100, n);
    total++;
    if (n !== 12) begin bad++; $display("FAIL rst_hb_first got=%0d want=12", n); end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    I_reset    = 1'b1;
    I_code     = 4'd0;
    I_code_vld = 1'b0;
    test_reset();
    test_heartbeat();
    test_blink3();
    test_mid_change();
    test_last_wins();
    test_limit();
    test_reset_mid_on();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_code.md
LED_CODE -- requirements
Module: led_code

Interface
REQ-001 SHALL have parameter P_TICK_DIV, default 2500000, clocks per tick (100 ms at 25 MHz); legal values are 2 or more.
REQ-002 SHALL have parameter P_ON_TICKS, default 2, LED-on ticks per blink; legal values are 1 or more.
REQ-003 SHALL have parameter P_OFF_TICKS, default 3, LED-off ticks after each blink; legal values are 1 or more.
REQ-004 SHALL have parameter P_GAP_TICKS, default 15, extra dark ticks after the last blink of a sequence; legal values are 1 or more.
REQ-005 SHALL have parameter P_HB_TICKS, default 6, heartbeat half-period in ticks when the code is 0; legal values are 1 or more.
REQ-006 SHALL have port I_clk  input  1  sole clock, 25 MHz.
REQ-007 SHALL have port I_reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port I_code  input  4  status/error code; 0 = healthy heartbeat, 1..15 = blink count.
REQ-009 SHALL have port I_code_vld  input  1  single-cycle strobe that loads I_code.
REQ-010 SHALL have port O_led  output  1  LED drive, registered, 1 = lit.
REQ-011 SHALL have port O_cur_code  output  4  code currently being displayed.
REQ-012 SHALL have port O_pend  output  1  a loaded code is waiting for the next commit point.

Function
REQ-013 SHALL count clocks 0..P_TICK_DIV-1 in a prescaler, assert the tick for one clock at P_TICK_DIV-1, then wrap to 0.
REQ-014 SHALL, on I_code_vld, store I_code in the pending register and set O_pend; on multiple strobes before a commit, the last strobe wins.
REQ-015 SHALL implement the states HB, ON, OFF and GAP; all phase durations are counted in ticks.
REQ-016 SHALL commit only at a commit point: any tick while in HB, or the tick that ends GAP.
REQ-017 SHALL, at a commit point with O_pend=1, copy the pending code to O_cur_code, clear O_pend, and clear the blink and phase counters.
REQ-018 SHALL, after a commit decision, enter ON with O_led=1 if the resulting code is nonzero, or enter HB with O_led=0 if it is 0.
REQ-019 SHALL, when GAP ends with O_pend=0 and a nonzero code, repeat the same code sequence starting from ON.
REQ-020 SHALL, in HB with no pending code, toggle O_led every P_HB_TICKS ticks.
REQ-021 SHALL leave ON after P_ON_TICKS ticks for OFF with O_led=0.
REQ-022 SHALL leave OFF after P_OFF_TICKS ticks, incrementing the blink counter; it goes to GAP if the count equals O_cur_code, else to ON.
REQ-023 SHALL use a 4-bit blink counter; code 15 yields exactly 15 blinks with no wrap-around.
REQ-024 SHALL treat a strobe in the same cycle as a commit tick as pending for the next commit point, and not commit it in that cycle.
REQ-025 SHALL NOT truncate a sequence in progress when a new code arrives; it completes first.
REQ-026 SHALL change O_led on the clock edge that consumes the tick (latency of one clock from tick to O_led).

Reset
REQ-027 SHALL, on I_reset=1 at a clock edge, clear the prescaler, phase and blink counters, the pending register, O_pend and O_cur_code, enter state HB, and set O_led=0.
REQ-028 SHALL take reset regardless of the current state, including mid-blink and mid-gap.

Structure
REQ-029 SHALL place the state encoding and the default parameter values in the shared package led_pkg.
REQ-030 SHALL implement the prescaler as the sub-module led_tick (parameter P_TICK_DIV, output single-cycle tick).

Verification
REQ-031 SHALL use bench parameters: P_TICK_DIV=4, P_ON_TICKS=2, P_OFF_TICKS=3, P_GAP_TICKS=5, P_HB_TICKS=3.
REQ-032 SHALL check heartbeat: release reset with no strobe -> O_led toggles every 12 clocks; O_cur_code=0; O_pend=0.
REQ-033 SHALL check blink code: strobe code 3 -> O_pend set, then cleared within 4 clocks; 3 pulses, each 8 clocks high, with 12 clocks low between pulses; then 32 clocks low; sequence repeats.
REQ-034 SHALL check mid-sequence change: code 3 running, strobe 1 during the 2nd pulse -> all 3 pulses complete, then a repeating 1-pulse sequence; O_cur_code=1 after the gap.
REQ-035 SHALL check last-wins: strobe 5 then 2 within one gap -> next sequence shows 2 pulses; code 5 is never shown.
REQ-036 SHALL check reset mid-ON -> O_led=0 on the next edge; state HB; O_cur_code=0.
REQ-037 SHALL check the limit case: strobe 15 -> exactly 15 pulses per sequence; strobe 0 afterwards -> heartbeat resumes after the gap.
